count_pwm: RTL and testbench
============================

Name: count_pwm

Overview:
- Downstream consumer of the free-running counter8bits `count` bus.
- Turns the counter value into a PWM waveform, using a double-buffered duty register that is written through a valid/ready handshake.
- Detects counter wrap-around to mark period boundaries and keeps a saturating count of completed periods.
- Sits between counter8bits and the board LED/pin outputs on the iCE40-HX8K breakout.

Parameters:
- SIZE, 8: width of `count` and `duty`; must match the upstream counter width.
- PCNT_W, 16: width of `period_cnt`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- count  input  SIZE  value from the upstream counter.
- duty  input  SIZE  requested duty, in counts high per period.
- duty_valid  input  1  `duty` is presented.
- duty_ready  output  1  block can accept a duty value.
- pwm  output  1  PWM output, registered.
- period_start  output  1  one-cycle pulse marking the first cycle of each period, registered.
- period_cnt  output  PCNT_W  number of wraps seen, saturating.

Behaviour:
- Reset (async, rst=1):
  - pwm=0, period_start=0, period_cnt=0, duty_ready=1.
  - count_q=0, prev_q=0, active_duty=0, pend_full=0.
  - State=SYNC.
- Input stage: every cycle count_q<=count and prev_q<=count_q.
- Wrap event: `wrap = (count_q < prev_q)`, evaluated combinationally each cycle.
  - Equal values (counter stall) are not a wrap.
  - Any decrease is a wrap, so jumps and skips are tolerated.
  - The first cycle after reset cannot wrap, because prev_q=0.
- States:
  - SYNC: pwm forced 0. On wrap -> RUN.
  - RUN: normal PWM. Stays in RUN until reset.
- Duty handshake:
  - duty_ready = !pend_full.
  - Accept when duty_valid && duty_ready: pending<=duty, pend_full<=1.
  - duty_valid is held by the source until accepted; duty must stay stable while valid is high.
- Shadow transfer:
  - On a wrap cycle with pend_full already 1 at that cycle's start: active_duty<=pending, pend_full<=0.
  - A value accepted in a wrap cycle (pend_full was 0) stays pending until the next wrap, i.e. it waits one full period.
  - Updates in SYNC follow the same rule; the first wrap loads any pending value.
- Compare (registered):
  - duty_eff = (wrap && pend_full) ? pending : active_duty.
  - pwm <= (state_next==RUN) && (count_q < duty_eff).
  - Latency: count change -> pwm change = 2 clk.
  - duty=0 -> pwm never high; duty=2^SIZE-1 -> high for 2^SIZE-1 of 2^SIZE counts.
- period_start:
  - Registered; equals 1 in the cycle after a wrap is detected.
  - Aligned with the first pwm value of the new period.
  - Also pulses on the SYNC->RUN wrap.
- period_cnt:
  - +1 on every wrap, including the SYNC->RUN wrap.
  - Saturates at 2^PCNT_W-1 and does not roll over.
- Simultaneous accept + wrap: the transfer uses the old pending (if full), and the acceptance fills the freed slot only if ready was already high. No value is lost or duplicated.
- Reset mid-operation: all outputs clear asynchronously; the pending value is discarded; the block re-enters SYNC and waits for the next wrap.

Optional Feature:
- Macro: COUNT_PWM_COMPL_EN.
- Defined: adds output port `pwm_n` (1 bit, registered, reset 0).
  - pwm_n <= RUN && !(count_q < duty_eff) && !pwm.
  - This gives a complementary output with one clk of dead time after each pwm falling edge.
  - pwm and pwm_n are never both 1.
  - In SYNC, pwm_n=0.
- Not defined: port `pwm_n` and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, counter free-running 0..255 per clk, no duty written -> pwm=0 throughout, duty_ready=1; period_start pulses once every 256 clk starting 2 clk after count goes 255->0; period_cnt increments 1,2,3.
- Write duty=64 at count=100 -> duty_ready low 1 cycle after the handshake; the next period has pwm high exactly 64 clk beginning in the period_start cycle; duty_ready=1 after the transfer.
- duty=0 then duty=255 on successive periods -> 0 high clk in the first period, 255 high clk then 1 low clk in the second.
- duty=10 accepted, then duty=20 held valid -> 20 is accepted the cycle after the wrap that loads 10; periods show 10 then 20 high clk.
- rst asserted at count=30 with duty=64 active (pwm=1) -> pwm, period_cnt and pend_full drop to 0 with no clk edge; after release, pwm stays 0 until the next wrap and then duty is 0.
- Hold count at 100 for 300 clk -> no period_start, period_cnt unchanged, pwm holds its value. With COUNT_PWM_COMPL_EN and duty=64: pwm_n is low at the pwm rise, rises 1 clk after pwm falls, and is never 1 together with pwm.

Source files
------------

// File: rtl/count_pwm.sv
// count_pwm: PWM generator driven by an external free-running counter bus, with
// double-buffered duty. Define COUNT_PWM_COMPL_EN to add the complementary output pwm_n.
module count_pwm #(
  parameter int SIZE   = 8,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   count,
  input  logic [SIZE-1:0]   duty,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm,
  output logic              period_start,
  output logic [PCNT_W-1:0] period_cnt
`ifdef COUNT_PWM_COMPL_EN
  ,
  output logic              pwm_n
`endif
);

  typedef enum logic {SYNC, RUN} state_t;

  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  state_t          state, state_next;
  logic [SIZE-1:0] count_q, prev_q;
  logic [SIZE-1:0] pending, active_duty, duty_eff;
  logic            pend_full, wrap, accept, below;

  // Any decrease of the sampled counter marks a new period; a stall is not a wrap.
  assign wrap       = count_q < prev_q;
  assign duty_ready = !pend_full;
  assign accept     = duty_valid && duty_ready;
  assign duty_eff   = (wrap && pend_full) ? pending : active_duty;
  assign below      = count_q < duty_eff;

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (wrap) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SYNC;
      count_q <= '0;
      prev_q  <= '0;
    end else begin
      state   <= state_next;
      count_q <= count;
      prev_q  <= count_q;
    end
  end

  // Transfer and accept are exclusive: accept needs an empty slot, transfer a full one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      active_duty <= '0;
      pend_full   <= 1'b0;
    end else if (wrap && pend_full) begin
      active_duty <= pending;
      pend_full   <= 1'b0;
    end else if (accept) begin
      pending   <= duty;
      pend_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm          <= 1'b0;
      period_start <= 1'b0;
      period_cnt   <= '0;
    end else begin
      pwm          <= (state_next == RUN) && below;
      period_start <= wrap;
      if (wrap && (period_cnt != PCNT_MAX))
        period_cnt <= period_cnt + 1'b1;
    end
  end

`ifdef COUNT_PWM_COMPL_EN
  // Qualifying with the current pwm inserts one clock of dead time after each fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pwm_n <= 1'b0;
    else
      pwm_n <= (state_next == RUN) && !below && !pwm;
  end
`endif

endmodule

// File: tb/tb_count_pwm.sv
// tb_count_pwm: scenario tasks plus randomized run, checked each clock against a
// period/buffer reference model held in the bench.
module tb_count_pwm;
  localparam int SIZE = 8;
  localparam int PW   = 6;
  localparam int PMAX = (1 << PW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] count = '0;
  logic [SIZE-1:0] duty = '0;
  logic            duty_valid = 1'b0;
  logic            duty_ready, pwm, period_start;
  logic [PW-1:0]   period_cnt;
`ifdef COUNT_PWM_COMPL_EN
  logic            pwm_n;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: last two counter samples, active duty, one-deep pending buffer.
  int m_cur, m_prev, m_active, m_periods;
  bit m_running, m_pwm;
  int m_pend[$];
  int req_q[$];
  int ctr = 0;
  int highs[$];
  int run_hi, ps_seen;

  count_pwm #(.SIZE(SIZE), .PCNT_W(PW)) dut (
    .clk(clk), .rst(rst), .count(count), .duty(duty), .duty_valid(duty_valid),
    .duty_ready(duty_ready), .pwm(pwm), .period_start(period_start),
    .period_cnt(period_cnt)
`ifdef COUNT_PWM_COMPL_EN
    , .pwm_n(pwm_n)
`endif
  );

  always #5 clk = ~clk;

  task model_reset();
    m_cur = 0; m_prev = 0; m_active = 0; m_periods = 0;
    m_running = 0; m_pwm = 0;
    m_pend.delete(); req_q.delete();
    run_hi = 0;
  endtask

  // One clock: drive inputs, predict, step, compare just after the edge.
  task cycle(input int cnt);
    bit wrap, accept, exp_pwm, exp_ready;
    int eff;
`ifdef COUNT_PWM_COMPL_EN
    bit exp_pwm_n;
`endif
    count      = SIZE'(cnt);
    duty_valid = (req_q.size() > 0);
    duty       = duty_valid ? SIZE'(req_q[0]) : '0;
    exp_ready  = (m_pend.size() == 0);
    tests++;
    if (duty_ready !== exp_ready) begin
      fails++;
      $display("[TB] FAIL duty_ready cyc=%0d got=%b exp=%b", cyc, duty_ready, exp_ready);
    end
    wrap   = m_cur < m_prev;
    accept = duty_valid && exp_ready;
    eff    = (wrap && m_pend.size() > 0) ? m_pend[0] : m_active;
    if (wrap) begin
      m_running = 1;
      if (m_periods < PMAX) m_periods++;
      if (m_pend.size() > 0) m_active = m_pend.pop_front();
    end
    if (accept) m_pend.push_back(req_q.pop_front());
`ifdef COUNT_PWM_COMPL_EN
    exp_pwm_n = m_running && !(m_cur < eff) && !m_pwm;
`endif
    exp_pwm = m_running && (m_cur < eff);
    m_pwm   = exp_pwm;
    m_prev  = m_cur;
    m_cur   = cnt;
    @(posedge clk);
    #1;
    cyc++;
    tests += 3;
    if (pwm !== exp_pwm) begin
      fails++;
      $display("[TB] FAIL pwm cyc=%0d got=%b exp=%b", cyc, pwm, exp_pwm);
    end
    if (period_start !== wrap) begin
      fails++;
      $display("[TB] FAIL period_start cyc=%0d got=%b exp=%b", cyc, period_start, wrap);
    end
    if (period_cnt !== PW'(m_periods)) begin
      fails++;
      $display("[TB] FAIL period_cnt cyc=%0d got=%0d exp=%0d", cyc, period_cnt, m_periods);
    end
`ifdef COUNT_PWM_COMPL_EN
    tests += 2;
    if (pwm_n !== exp_pwm_n) begin
      fails++;
      $display("[TB] FAIL pwm_n cyc=%0d got=%b exp=%b", cyc, pwm_n, exp_pwm_n);
    end
    if (pwm && pwm_n) begin
      fails++;
      $display("[TB] FAIL overlap cyc=%0d got=11 exp=not both", cyc);
    end
`endif
    if (period_start) begin
      highs.push_back(run_hi);
      run_hi = 0;
      ps_seen++;
    end
    if (pwm) run_hi++;
  endtask

  task run_free(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(ctr);
      ctr = (ctr + 1) % 256;
    end
  endtask

  task run_until_ctr(input int v);
    for (int i = 0; i < 256 && ctr != v; i++) begin
      cycle(ctr);
      ctr = (ctr + 1) % 256;
    end
  endtask

  task do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task check_high(input string name, input int idx, input int exp);
    tests++;
    if (highs.size() <= idx) begin
      fails++;
      $display("[TB] FAIL %s got=%0d periods exp=more than %0d", name, highs.size(), idx);
    end else if (highs[idx] != exp) begin
      fails++;
      $display("[TB] FAIL %s got=%0d high exp=%0d high", name, highs[idx], exp);
    end
  endtask

  task test_reset();
    #1;
    tests += 4;
    if (pwm !== 1'b0) begin fails++; $display("[TB] FAIL rst_pwm got=%b exp=0", pwm); end
    if (period_start !== 1'b0) begin fails++; $display("[TB] FAIL rst_ps got=%b exp=0", period_start); end
    if (period_cnt !== '0) begin fails++; $display("[TB] FAIL rst_pcnt got=%0d exp=0", period_cnt); end
    if (duty_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_ready got=%b exp=1", duty_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task test_free_run();
    ctr = 0;
    ps_seen = 0;
    run_free(3 * 256 + 10);
    tests += 2;
    if (period_cnt !== PW'(3)) begin fails++; $display("[TB] FAIL free_pcnt got=%0d exp=3", period_cnt); end
    if (ps_seen != 3) begin fails++; $display("[TB] FAIL free_ps got=%0d exp=3", ps_seen); end
  endtask

  task test_duty_write();
    do_reset();
    run_free(300);
    run_until_ctr(100);
    req_q.push_back(64);
    highs.delete();
    run_free(600);
    check_high("duty64", highs.size() - 1, 64);
  endtask

  task test_extremes();
    do_reset();
    run_free(300);
    run_until_ctr(0);
    req_q.push_back(0);
    req_q.push_back(255);
    highs.delete();
    run_hi = 0;
    run_free(3 * 256);
    check_high("duty0", 1, 0);
    check_high("duty255", 2, 255);
  endtask

  task test_back_to_back();
    do_reset();
    run_free(300);
    run_until_ctr(100);
    req_q.push_back(10);
    req_q.push_back(20);
    highs.delete();
    run_hi = 0;
    run_free(3 * 256);
    check_high("b2b_10", 1, 10);
    check_high("b2b_20", 2, 20);
  endtask

  task test_reset_mid();
    int i;
    do_reset();
    run_free(300);
    req_q.push_back(64);
    req_q.push_back(5);
    for (i = 0; i < 800 && !(m_active == 64 && ctr == 31); i++) begin
      cycle(ctr);
      ctr = (ctr + 1) % 256;
    end
    tests++;
    if (i >= 800) begin
      fails++;
      $display("[TB] FAIL mid_setup got=timeout exp=duty 64 active at count 30");
    end
    rst = 1'b1;
    #1;
    tests += 3;
    if (pwm !== 1'b0) begin fails++; $display("[TB] FAIL mid_pwm got=%b exp=0", pwm); end
    if (period_cnt !== '0) begin fails++; $display("[TB] FAIL mid_pcnt got=%0d exp=0", period_cnt); end
    if (duty_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_ready got=%b exp=1", duty_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    highs.delete();
    run_free(600);
    check_high("mid_after", 1, 0);
  endtask

  task test_stall();
    do_reset();
    run_free(300);
    req_q.push_back(64);
    run_free(300);
    run_until_ctr(101);
    ps_seen = 0;
    for (int i = 0; i < 300; i++) cycle(100);
    tests++;
    if (ps_seen != 0) begin fails++; $display("[TB] FAIL stall_ps got=%0d exp=0", ps_seen); end
    run_free(300);
  endtask

  task test_saturate();
    do_reset();
    for (int i = 0; i < 200; i++) cycle((i % 2 == 0) ? 1 : 0);
    tests++;
    if (period_cnt !== PW'(PMAX)) begin fails++; $display("[TB] FAIL sat_pcnt got=%0d exp=%0d", period_cnt, PMAX); end
  endtask

  task test_random();
    int r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) ctr = $urandom_range(0, 255);
      else if (r >= 6) ctr = (ctr + 1) % 256;
      if (req_q.size() == 0 && $urandom_range(0, 199) == 0)
        req_q.push_back($urandom_range(0, 255));
      cycle(ctr);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_duty_write();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
